// File: rtl/sipo_ctrl_pkg.sv
// Shared state type and sizing helpers for the SIPO frame controller.
// Defining SIPO_PARITY_CHECK_EN appends one even-parity bit to every frame.
package sipo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } sipo_state_t;

  localparam int DEFAULT_WORD_WIDTH = 16;

`ifdef SIPO_PARITY_CHECK_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Width needed to hold a count from 0 up to and including frame_bits.
  function automatic int count_width(input int frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_stage.sv
// Enable-gated, clearable shift register; MSB_FIRST selects the shift direction.
module sipo_shift_stage #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shift_reg;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      shift_reg <= '0;
    end else if (en) begin
      if (MSB_FIRST) begin
        shift_reg <= {shift_reg[WIDTH-2:0], din};
      end else begin
        shift_reg <= {din, shift_reg[WIDTH-1:1]};
      end
    end
  end

  assign q = shift_reg;

endmodule

// File: rtl/sipo_frame_controller.sv
// Frames serial bits into words and hands them downstream over valid/ready.
// Defining SIPO_PARITY_CHECK_EN adds a trailing parity bit and Parity_Error_Out.
module sipo_frame_controller
  import sipo_ctrl_pkg::*;
#(
  parameter int  WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter bit  MSB_FIRST  = 1'b1,
  localparam int FRAME_BITS = WORD_WIDTH + PARITY_BITS,
  localparam int CW         = count_width(FRAME_BITS)
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Frame_Start_In,
  input  logic                  Serial_Data_In,
  input  logic                  Bit_Valid_In,
  input  logic                  Word_Ready_In,
  output logic [WORD_WIDTH-1:0] Word_Data_Out,
  output logic                  Word_Valid_Out,
  output logic                  Busy_Out,
  output logic [CW-1:0]         Bit_Count_Out,
`ifdef SIPO_PARITY_CHECK_EN
  output logic                  Parity_Error_Out,
`endif
  output logic                  Overrun_Out
);

  localparam logic [CW-1:0] LAST_COUNT = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] WORD_COUNT = CW'(WORD_WIDTH);

  sipo_state_t           state_reg;
  logic [CW-1:0]         count_reg;
  logic [WORD_WIDTH-1:0] word_reg;
  logic                  valid_reg;
  logic                  busy_reg;
  logic                  overrun_reg;
  logic [WORD_WIDTH-1:0] shift_q;
  logic [WORD_WIDTH-1:0] captured;
  logic                  handshake;
  logic                  accept;
  logic                  last_bit;
  logic                  shift_clr;
  logic                  shift_en;

  always_comb begin
    handshake = (state_reg == HOLD) && valid_reg && Word_Ready_In;
    accept    = (state_reg == SHIFT) && Bit_Valid_In && !Frame_Start_In;
    last_bit  = accept && (count_reg == LAST_COUNT);
    shift_clr = Frame_Start_In && ((state_reg != HOLD) || handshake);
    // A trailing parity bit is counted but never shifted into the word.
    shift_en  = accept && (count_reg < WORD_COUNT);
`ifdef SIPO_PARITY_CHECK_EN
    captured = shift_q;
`else
    // The final bit is still in flight, so the word is the register's next value.
    captured = MSB_FIRST ? {shift_q[WORD_WIDTH-2:0], Serial_Data_In}
                         : {Serial_Data_In, shift_q[WORD_WIDTH-1:1]};
`endif
  end

  sipo_shift_stage #(
    .WIDTH     (WORD_WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk  (Clk_In),
    .srst (Reset_In),
    .clr  (shift_clr),
    .en   (shift_en),
    .din  (Serial_Data_In),
    .q    (shift_q)
  );

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      word_reg    <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Frame_Start_In) begin
            state_reg <= SHIFT;
            count_reg <= '0;
            busy_reg  <= 1'b1;
          end
        end
        SHIFT: begin
          if (Frame_Start_In) begin
            count_reg <= '0;
          end else if (accept) begin
            count_reg <= count_reg + 1'b1;
            if (last_bit) begin
              state_reg <= HOLD;
              word_reg  <= captured;
              valid_reg <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (Bit_Valid_In) begin
            overrun_reg <= 1'b1;
          end
          if (handshake) begin
            valid_reg <= 1'b0;
            count_reg <= '0;
            state_reg <= Frame_Start_In ? SHIFT : IDLE;
            busy_reg  <= Frame_Start_In;
          end else if (Frame_Start_In) begin
            overrun_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          valid_reg <= 1'b0;
          count_reg <= '0;
        end
      endcase
    end
  end

`ifdef SIPO_PARITY_CHECK_EN
  logic parity_err_reg;

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      parity_err_reg <= 1'b0;
    end else if (last_bit) begin
      parity_err_reg <= (^shift_q) ^ Serial_Data_In;
    end else if (handshake) begin
      parity_err_reg <= 1'b0;
    end
  end

  assign Parity_Error_Out = parity_err_reg;
`endif

  assign Word_Data_Out  = word_reg;
  assign Word_Valid_Out = valid_reg;
  assign Busy_Out       = busy_reg;
  assign Bit_Count_Out  = count_reg;
  assign Overrun_Out    = overrun_reg;

endmodule

// File: tb/tb_sipo_frame_controller.sv
// Directed bench for sipo_frame_controller: an MSB-first and an LSB-first instance share stimulus.
// Honours SIPO_PARITY_CHECK_EN by appending the parity bit and checking Parity_Error_Out.
module tb_sipo_frame_controller;
  import sipo_ctrl_pkg::*;

  localparam int W  = 16;
  localparam int FB = W + PARITY_BITS;
  localparam int CW = count_width(FB);

  logic          clk = 1'b0;
  logic          rst, fs, sd, bv, rdy;
  logic [W-1:0]  data_m, data_l;
  logic          valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;
  logic [CW-1:0] cnt_m, cnt_l;
`ifdef SIPO_PARITY_CHECK_EN
  logic          perr_m, perr_l;
  logic          exp_p_q[$];
`endif

  logic [W-1:0] exp_m_q[$];
  logic [W-1:0] exp_l_q[$];
  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  sipo_frame_controller #(.WORD_WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .Clk_In         (clk),
    .Reset_In       (rst),
    .Frame_Start_In (fs),
    .Serial_Data_In (sd),
    .Bit_Valid_In   (bv),
    .Word_Ready_In  (rdy),
    .Word_Data_Out  (data_m),
    .Word_Valid_Out (valid_m),
    .Busy_Out       (busy_m),
    .Bit_Count_Out  (cnt_m),
`ifdef SIPO_PARITY_CHECK_EN
    .Parity_Error_Out (perr_m),
`endif
    .Overrun_Out    (ovr_m)
  );

  sipo_frame_controller #(.WORD_WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .Clk_In         (clk),
    .Reset_In       (rst),
    .Frame_Start_In (fs),
    .Serial_Data_In (sd),
    .Bit_Valid_In   (bv),
    .Word_Ready_In  (rdy),
    .Word_Data_Out  (data_l),
    .Word_Valid_Out (valid_l),
    .Busy_Out       (busy_l),
    .Bit_Count_Out  (cnt_l),
`ifdef SIPO_PARITY_CHECK_EN
    .Parity_Error_Out (perr_l),
`endif
    .Overrun_Out    (ovr_l)
  );

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [W-1:0] v, input logic flip);
    exp_m_q.push_back(v);
    exp_l_q.push_back(bitrev(v));
`ifdef SIPO_PARITY_CHECK_EN
    exp_p_q.push_back(flip);
`else
    if (flip) $display("note: parity flip ignored without parity build");
`endif
  endtask

  task automatic start_frame(input logic with_bit, input string tag);
    fs = 1'b1; bv = with_bit; sd = 1'b1;
    step();
    fs = 1'b0; bv = 1'b0; sd = 1'b0;
    check({tag, "_start_count"}, cnt_m, 0);
    check({tag, "_start_busy"}, busy_m, 1);
  endtask

  // Sends the top n bits of v, most significant first.
  task automatic send_bits(input logic [W-1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bv = 1'b1; sd = v[W-1-i];
      step();
    end
    bv = 1'b0; sd = 1'b0;
  endtask

  task automatic send_payload(input logic [W-1:0] v, input logic flip);
    send_bits(v, W);
`ifdef SIPO_PARITY_CHECK_EN
    bv = 1'b1; sd = (^v) ^ flip;
    step();
    bv = 1'b0; sd = 1'b0;
`else
    if (flip) $display("note: no parity bit sent");
`endif
  endtask

  task automatic send_word(input logic [W-1:0] v, input logic flip, input logic with_bit, input string tag);
    push_exp(v, flip);
    start_frame(with_bit, tag);
    send_payload(v, flip);
  endtask

  // Called on the cycle right after the final strobe, so it also pins the 1-cycle latency.
  task automatic check_word(input string tag);
    check({tag, "_valid_m"}, valid_m, 1);
    check({tag, "_valid_l"}, valid_l, 1);
    if (exp_m_q.size() == 0 || exp_l_q.size() == 0) begin
      n_total++;
      $error("FAIL %s: scoreboard empty observed=%0h expected=queued_word", tag, data_m);
    end else begin
      check({tag, "_data_m"}, data_m, exp_m_q.pop_front());
      check({tag, "_data_l"}, data_l, exp_l_q.pop_front());
    end
`ifdef SIPO_PARITY_CHECK_EN
    if (exp_p_q.size() != 0) check({tag, "_perr"}, perr_m, exp_p_q.pop_front());
`endif
  endtask

  initial begin
    rst = 1'b1; fs = 1'b0; sd = 1'b0; bv = 1'b0; rdy = 1'b0;
    step(); step();
    check("rst_valid", valid_m, 0);
    check("rst_data", data_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_count", cnt_m, 0);
    check("rst_ovr", ovr_m, 0);
    check("rst_valid_l", valid_l, 0);
    rst = 1'b0;

    // Nominal word with downstream always ready
    rdy = 1'b1;
    send_word(16'hA5C3, 1'b0, 1'b0, "nom");
    check_word("nom");
    check("nom_count_sat", cnt_m, FB);
    check("nom_busy_hold", busy_m, 1);
    step();
    check("nom_valid_drop", valid_m, 0);
    check("nom_busy_idle", busy_m, 0);
    check("nom_count_clr", cnt_m, 0);
`ifdef SIPO_PARITY_CHECK_EN
    check("nom_perr_idle", perr_m, 0);
`endif

    // Backpressure with one stray strobe while holding
    rdy = 1'b0;
    send_word(16'hA5C3, 1'b0, 1'b0, "bp");
    check_word("bp");
    for (int i = 0; i < 5; i++) begin
      bv = (i == 2); sd = 1'b1;
      step();
      bv = 1'b0; sd = 1'b0;
      check($sformatf("bp_valid_%0d", i), valid_m, 1);
      check($sformatf("bp_data_%0d", i), data_m, 16'hA5C3);
      check($sformatf("bp_count_%0d", i), cnt_m, FB);
      check($sformatf("bp_ovr_%0d", i), ovr_m, (i >= 2) ? 1 : 0);
    end
    rdy = 1'b1;
    step();
    check("bp_valid_drop", valid_m, 0);
    check("bp_ovr_sticky", ovr_m, 1);
    step();
    check("bp_ovr_sticky2", ovr_m, 1);
    check("bp_ovr_sticky_l", ovr_l, 1);

    // Restart mid-frame; the strobe alongside the restart is not sampled
    rst = 1'b1; step(); rst = 1'b0;
    check("rs_ovr_cleared", ovr_m, 0);
    start_frame(1'b0, "rs_first");
    send_bits(16'hFE00, 7);
    check("rs_count7", cnt_m, 7);
    send_word(16'h1234, 1'b0, 1'b1, "rs");
    check_word("rs");
    check("rs_ovr", ovr_m, 0);
    step();

    // Bit order: 1 then fifteen 0s
    send_word(16'h8000, 1'b0, 1'b0, "ord");
    check("ord_lsb_first", data_l, 16'h0001);
    check_word("ord");
    step();

    // Reset mid-frame, then strobes ignored until a frame start
    start_frame(1'b0, "mr_first");
    send_bits(16'hFF00, 8);
    check("mr_count8", cnt_m, 8);
    rst = 1'b1; step(); rst = 1'b0;
    check("mr_valid", valid_m, 0);
    check("mr_data", data_m, 0);
    check("mr_busy", busy_m, 0);
    check("mr_count", cnt_m, 0);
    check("mr_ovr", ovr_m, 0);
    send_bits(16'hE000, 3);
    check("mr_idle_count", cnt_m, 0);
    check("mr_idle_busy", busy_m, 0);
    send_word(16'hFFFF, 1'b0, 1'b1, "mr");
    check_word("mr");
    step();

    // Handshake and frame start together in HOLD: straight back to SHIFT, no overrun
    rdy = 1'b0;
    send_word(16'h0F0F, 1'b0, 1'b0, "hs");
    check_word("hs");
    fs = 1'b1; rdy = 1'b1;
    step();
    fs = 1'b0;
    check("hs_busy", busy_m, 1);
    check("hs_valid", valid_m, 0);
    check("hs_count", cnt_m, 0);
    check("hs_ovr", ovr_m, 0);
    push_exp(16'h3C5A, 1'b0);
    send_payload(16'h3C5A, 1'b0);
    check_word("hs2");
    check("hs2_ovr", ovr_m, 0);
    step();

`ifdef SIPO_PARITY_CHECK_EN
    // Wrong parity bit flags an error only while the word is valid
    send_word(16'hA5C3, 1'b1, 1'b0, "par");
    check_word("par");
    step();
    check("par_clear", perr_m, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
